sr_latch_driver: RTL and testbench

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_latch_driver.sv | 158 +++++++++++++++
 tb/tb_sr_latch_driver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - pulsed S/R driver for a NOR-pair latch with feedback confirm (option: SR_LATCH_DRIVER_SYNC_EN)
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_value,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q_fb,
    input  logic Qn_fb,
    output logic done,
    output logic err,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam logic [7:0] PULSE_LOAD   = 8'(PULSE_W - 1);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] blank_q, blank_d;
    logic       value_q, value_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       fb_q;
    logic       fb_qn;

`ifdef SR_LATCH_DRIVER_SYNC_EN
    // Synchronised feedback lags the latch by two cycles, so the first two
    // SETTLE cycles are blanked to let a fresh sample reach the comparator.
    localparam logic [1:0] BLANK_LOAD = 2'd2;

    logic [1:0] q_sync_q;
    logic [1:0] qn_sync_q;

    // Two-flop synchronizer on the latch readback, reset to the Q=0 pair
    always_ff @(posedge clk) begin
        if (rst) begin
            q_sync_q  <= 2'b00;
            qn_sync_q <= 2'b11;
        end else begin
            q_sync_q  <= {q_sync_q[0], Q_fb};
            qn_sync_q <= {qn_sync_q[0], Qn_fb};
        end
    end

    assign fb_q  = q_sync_q[1];
    assign fb_qn = qn_sync_q[1];
`else
    localparam logic [1:0] BLANK_LOAD = 2'd0;

    assign fb_q  = Q_fb;
    assign fb_qn = Qn_fb;
`endif

    // A complementary pair equal to the wanted value; Q==Qn never matches
    function automatic logic fb_match(input logic v, input logic q, input logic qn);
        return (q != qn) && (q == v);
    endfunction

    // Next-state, counters and registered drive/pulse outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        value_d = value_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    value_d = req_value;
                    if (fb_match(req_value, fb_q, fb_qn)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LOAD;
                        s_d     = req_value;
                        r_d     = ~req_value;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = SETTLE;
                    cnt_d   = TIMEOUT_LOAD;
                    blank_d = BLANK_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    s_d   = value_q;
                    r_d   = ~value_q;
                end
            end
            SETTLE: begin
                if (blank_q != 2'd0) begin
                    blank_d = blank_q - 2'd1;
                end else if (fb_match(value_q, fb_q, fb_qn)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            blank_q <= 2'd0;
            value_q <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            value_q <= value_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the drives immediately so an aborted pulse drops in the rst cycle
    assign S         = s_q & ~rst;
    assign R         = r_q & ~rst;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - scoreboard bench for sr_latch_driver with a NOR-pair latch model
module tb_sr_latch_driver;

`ifdef SR_LATCH_DRIVER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int DONE_AT = 6 + LAT;
    localparam int ERR_AT  = 21 + LAT;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic req_value;
    logic req_ready;
    logic S;
    logic R;
    logic Q_fb;
    logic Qn_fb;
    logic done;
    logic err;
    logic busy;

    logic lat_q  = 1'b0;
    logic frc_en = 1'b0;
    logic frc_q  = 1'b0;
    logic frc_qn = 1'b0;

    typedef struct {
        bit is_err;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_chk   = 0;
    bit   overlap = 1'b0;

    sr_latch_driver #(.PULSE_W(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_value(req_value),
        .req_ready(req_ready),
        .S        (S),
        .R        (R),
        .Q_fb     (Q_fb),
        .Qn_fb    (Qn_fb),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(S or R) begin
        if (S && !R)      lat_q = 1'b1;
        else if (R && !S) lat_q = 1'b0;
    end

    assign Q_fb  = frc_en ? frc_q  : lat_q;
    assign Qn_fb = frc_en ? frc_qn : ~lat_q;

    task automatic check(input string name, input logic act, input logic req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic push(input bit is_err, input int at);
        exp_t e;
        e.is_err = is_err;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic v, output int t0);
        @(posedge clk);
        #1;
        check("ready_at_issue", req_ready, 1'b1);
        req_valid = 1'b1;
        req_value = v;
        t0 = cyc;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !req_ready) && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k < 60) n_pass++;
        else $display("FAIL wait_idle: pending=%0d ready=%0b after %0d cycles", exp_q.size(), req_ready, k);
        @(negedge clk);
    endtask

    // Monitor: every done/err pulse is matched against the scoreboard queue
    always @(negedge clk) begin
        if (S && R) overlap = 1'b1;
        if (done || err) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: done=%0b err=%0b at cycle %0d, expected none", done, err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_err", err, mon_e.is_err);
                check("sb_done", done, !mon_e.is_err);
                check_int("sb_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_value = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_S", S, 1'b0);
        check("rst_R", R, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        // Latch Q=0, write 1: S for cycles 1-4, done at DONE_AT
        issue(1'b1, t0);
        push(1'b0, t0 + DONE_AT);
        for (int i = 1; i <= DONE_AT; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) req_valid = 1'b0;
            @(negedge clk);
            check("w1_S", S, (i <= 4));
            check("w1_R", R, 1'b0);
            if (i == DONE_AT - 1) check("w1_busy_ready", req_ready, 1'b0);
            if (i == DONE_AT)     check("w1_ready", req_ready, 1'b1);
        end
        wait_idle();

        // Latch Q=1, write 1: skip, done in cycle 1
        issue(1'b1, t0);
        push(1'b0, t0 + 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("skip_S", S, 1'b0);
        check("skip_R", R, 1'b0);
        check("skip_busy", busy, 1'b0);
        wait_idle();

        // Write 0; req_value flips after acceptance and must be ignored
        issue(1'b0, t0);
        push(1'b0, t0 + DONE_AT);
        for (int i = 1; i <= DONE_AT; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                req_valid = 1'b0;
                req_value = 1'b1;
            end
            @(negedge clk);
            check("w0_R", R, (i <= 4));
            check("w0_S", S, 1'b0);
        end
        wait_idle();

        // Feedback stuck at Q=0: write 1 times out, R never pulses
        frc_en = 1'b1;
        frc_q  = 1'b0;
        frc_qn = 1'b1;
        repeat (3) @(posedge clk);
        issue(1'b1, t0);
        push(1'b1, t0 + ERR_AT);
        for (int i = 1; i <= ERR_AT; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) req_valid = 1'b0;
            @(negedge clk);
            check("tmo_R", R, 1'b0);
            if (i <= 5) check("tmo_S", S, (i <= 4));
        end
        wait_idle();

        // Forbidden Q==Qn pair never matches: no skip, pulse, then timeout
        frc_q  = 1'b1;
        frc_qn = 1'b1;
        repeat (3) @(posedge clk);
        issue(1'b1, t0);
        push(1'b1, t0 + ERR_AT);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("forbid_S", S, 1'b1);
        check("forbid_busy", busy, 1'b1);
        wait_idle();
        frc_en = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in cycle 2 of a write-0 pulse aborts with no done/err
        issue(1'b0, t0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_R_c1", R, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_R_c2", R, 1'b0);
        check("abort_S_c2", S, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_c3", req_ready, 1'b1);
        check("abort_busy_c3", busy, 1'b0);
        check("abort_R_c3", R, 1'b0);
        repeat (25) @(negedge clk);

        // Back-to-back writes 1,0,1 with req_valid held
        issue(1'b1, t0);
        push(1'b0, t0 + DONE_AT);
        push(1'b0, t0 + 2 * DONE_AT);
        push(1'b0, t0 + 3 * DONE_AT);
        for (int i = 1; i <= 3 * DONE_AT; i++) begin
            @(posedge clk);
            #1;
            if (i == 1)               req_value = 1'b0;
            if (i == DONE_AT + 1)     req_value = 1'b1;
            if (i == 2 * DONE_AT + 1) req_valid = 1'b0;
            @(negedge clk);
            check("b2b_S", S, (i <= 4) || (i > 2 * DONE_AT && i <= 2 * DONE_AT + 4));
            check("b2b_R", R, (i > DONE_AT && i <= DONE_AT + 4));
        end
        wait_idle();

        check("no_S_R_overlap", overlap, 1'b0);
        check_int("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
